fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_rdr_pkg.sv | 20 ++
 rtl/fifo_rdr_skid.sv | 79 +++++++
 rtl/fifo_stream_reader.sv | 89 ++++++++
 tb/tb_fifo_stream_reader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rdr_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fifo_rdr_pkg : shared constants and types for the FIFO stream reader    |
// | Revision     : 1.0                                                      |
// +-------------------------------------------------------------------------+
package fifo_rdr_pkg;

  localparam int RDR_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } rdr_state_e;

  // Occupancy shares the state encoding, so the state register doubles as the count.
  typedef logic [1:0] rdr_occ_t;

endpackage
`default_nettype wire

// File: rtl/fifo_rdr_skid.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fifo_rdr_skid : two-entry skid buffer presenting a valid/ready stream   |
// | Revision      : 1.0                                                     |
// +-------------------------------------------------------------------------+
module fifo_rdr_skid
  import fifo_rdr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output rdr_occ_t         o_occ
);

  localparam logic [1:0] ST_EMPTY = EMPTY;
  localparam logic [1:0] ST_ONE   = ONE;
  localparam logic [1:0] ST_TWO   = TWO;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             w_xfer;

  assign w_xfer  = o_valid && i_ready;
  assign o_valid = (r_state == ST_ONE) || (r_state == ST_TWO);
  assign o_data  = r_head;
  assign o_occ   = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (i_clr) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (i_wr_en) begin
            r_head  <= i_wr_data;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          case ({i_wr_en, w_xfer})
            2'b11: r_head <= i_wr_data;
            2'b01: r_state <= ST_EMPTY;
            2'b10: begin
              r_tail  <= i_wr_data;
              r_state <= ST_TWO;
            end
            default: ;
          endcase
        end
        ST_TWO: begin
          // A write without a transfer cannot happen here: the credit check upstream forbids it.
          if (w_xfer) begin
            r_head <= r_tail;
            if (i_wr_en) begin
              r_tail <= i_wr_data;
            end else begin
              r_state <= ST_ONE;
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fifo_stream_reader : pops a sync FIFO into a valid/ready stream         |
// | Option macro FIFO_RDR_STATS_EN adds the 32-bit pop_count output.        |
// | Revision           : 1.0                                                |
// +-------------------------------------------------------------------------+
module fifo_stream_reader
  import fifo_rdr_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int REGOUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  input  logic             fifo_empty,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
`ifdef FIFO_RDR_STATS_EN
  ,
  output logic [31:0]      pop_count
`endif
);

  rdr_occ_t   w_occ;
  logic [1:0] r_inflight;
  logic [2:0] w_demand;
  logic       w_land;
  logic       w_xfer;

  assign w_xfer   = m_valid && m_ready;
  assign w_demand = {1'b0, w_occ} + {1'b0, r_inflight} - {2'b00, w_xfer};

  // rst_n gating keeps the pop strobe quiet while the buffer is held in reset.
  assign fifo_rd_en = rst_n && !fifo_empty && !clr && (w_demand < 3'(RDR_BUF_DEPTH));

  generate
    if (REGOUT != 0) begin : g_regout
      assign w_land = (r_inflight != 2'd0);
    end else begin : g_comb
      assign w_land = fifo_rd_en;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 2'd0;
    end else if (clr) begin
      r_inflight <= 2'd0;
    end else begin
      r_inflight <= r_inflight + {1'b0, fifo_rd_en} - {1'b0, w_land};
    end
  end

  fifo_rdr_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (clr),
    .i_wr_en  (w_land),
    .i_wr_data(fifo_rd_data),
    .i_ready  (m_ready),
    .o_valid  (m_valid),
    .o_data   (m_data),
    .o_occ    (w_occ)
  );

`ifdef FIFO_RDR_STATS_EN
  logic [31:0] r_pop_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_count <= 32'd0;
    end else if (clr) begin
      r_pop_count <= 32'd0;
    end else if (w_xfer) begin
      r_pop_count <= r_pop_count + 32'd1;
    end
  end

  assign pop_count = r_pop_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// Scoreboard bench: one reader with registered FIFO output, one with combinational output,
// both fed the same word stream and the same m_ready/clr/rst_n.
module tb_fifo_stream_reader;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic m_ready = 1'b0;

  always #5 clk = ~clk;

  // Behavioural FIFO: one storage array, a read pointer per consumer.
  logic [W-1:0] mem [0:1023];
  logic [9:0]   wp = 10'd0;
  logic [9:0]   rp_a, rp_b;
  logic         rd_en_a, rd_en_b, empty_a, empty_b, v_a, v_b;
  logic [W-1:0] rdata_a, rdata_b, d_a, d_b;
`ifdef FIFO_RDR_STATS_EN
  logic [31:0]  pc_a, pc_b;
`endif

  assign empty_a = (rp_a == wp);
  assign empty_b = (rp_b == wp);
  assign rdata_b = mem[rp_b];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp_a    <= wp;
      rp_b    <= wp;
      rdata_a <= '0;
    end else begin
      if (rd_en_a) begin
        rdata_a <= mem[rp_a];
        rp_a    <= rp_a + 10'd1;
      end
      if (rd_en_b) rp_b <= rp_b + 10'd1;
    end
  end

  fifo_stream_reader #(.WIDTH(W), .REGOUT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .fifo_rd_en(rd_en_a), .fifo_rd_data(rdata_a), .fifo_empty(empty_a),
    .m_valid(v_a), .m_data(d_a), .m_ready(m_ready)
`ifdef FIFO_RDR_STATS_EN
    , .pop_count(pc_a)
`endif
  );

  fifo_stream_reader #(.WIDTH(W), .REGOUT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .fifo_rd_en(rd_en_b), .fifo_rd_data(rdata_b), .fifo_empty(empty_b),
    .m_valid(v_b), .m_data(d_b), .m_ready(m_ready)
`ifdef FIFO_RDR_STATS_EN
    , .pop_count(pc_b)
`endif
  );

  logic [W-1:0] exp_a [$];
  logic [W-1:0] exp_b [$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Words handed out but not yet accepted downstream: never more than the buffer depth.
  int out_a, out_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      out_a <= 0;
      out_b <= 0;
    end else begin
      out_a <= out_a + int'(rd_en_a) - int'(v_a && m_ready);
      out_b <= out_b + int'(rd_en_b) - int'(v_b && m_ready);
    end
  end

  logic         pv_a = 1'b0, pv_b = 1'b0, pr = 1'b0, pclr = 1'b0;
  logic [W-1:0] pd_a, pd_b, mw;
  bit           bub_en = 0, seen_a = 0, seen_b = 0, rdwin = 0;
  int           bub_a = 0, bub_b = 0, rdcnt_a = 0, rdcnt_b = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (v_a && m_ready) begin
        if (exp_a.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_extra_word: got %0h want none", d_a);
        end else begin
          mw = exp_a.pop_front();
          chk("a_data", 32'(d_a), 32'(mw));
        end
      end
      if (v_b && m_ready) begin
        if (exp_b.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_extra_word: got %0h want none", d_b);
        end else begin
          mw = exp_b.pop_front();
          chk("b_data", 32'(d_b), 32'(mw));
        end
      end
      if (!pclr && pv_a && !pr) begin
        chk("a_hold_valid", 32'(v_a), 32'd1);
        chk("a_hold_data", 32'(d_a), 32'(pd_a));
      end
      if (!pclr && pv_b && !pr) begin
        chk("b_hold_valid", 32'(v_b), 32'd1);
        chk("b_hold_data", 32'(d_b), 32'(pd_b));
      end
      if (pclr) begin
        chk("a_valid_after_clr", 32'(v_a), 32'd0);
        chk("b_valid_after_clr", 32'(v_b), 32'd0);
      end
      if (clr) begin
        chk("a_rden_in_clr", 32'(rd_en_a), 32'd0);
        chk("b_rden_in_clr", 32'(rd_en_b), 32'd0);
      end
      chk("a_outstanding_le2", 32'(out_a <= 2), 32'd1);
      chk("b_outstanding_le2", 32'(out_b <= 2), 32'd1);
      if (bub_en) begin
        if (v_a) seen_a = 1;
        else if (seen_a && m_ready && exp_a.size() > 0) bub_a++;
        if (v_b) seen_b = 1;
        else if (seen_b && m_ready && exp_b.size() > 0) bub_b++;
      end
      if (rdwin) begin
        rdcnt_a += int'(rd_en_a);
        rdcnt_b += int'(rd_en_b);
      end
      pv_a = v_a; pv_b = v_b; pd_a = d_a; pd_b = d_b; pr = m_ready; pclr = clr;
    end else begin
      pv_a = 1'b0; pv_b = 1'b0; pclr = 1'b0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [W-1:0] w);
    mem[wp] = w;
    wp = wp + 10'd1;
    exp_a.push_back(w);
    exp_b.push_back(w);
  endtask

  task automatic drain(input string nm, input int lim);
    int k = 0;
    while ((exp_a.size() + exp_b.size()) != 0 && k < lim) begin
      tick();
      k++;
    end
    chk(nm, 32'(exp_a.size() + exp_b.size()), 32'd0);
    tick();
  endtask

  task automatic bub_start();
    bub_a = 0; bub_b = 0; seen_a = 0; seen_b = 0; bub_en = 1;
  endtask

  // Cycle 0 is the cycle in which fifo_empty falls; report the first cycle with m_valid.
  task automatic latency(output int la, output int lb);
    la = -1; lb = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (v_a && la < 0) la = k;
      if (v_b && lb < 0) lb = k;
    end
    #1;
  endtask

  int la, lb;

  initial begin
    #3;
    chk("rst_valid_a", 32'(v_a), 32'd0);
    chk("rst_valid_b", 32'(v_b), 32'd0);
    chk("rst_data_a", 32'(d_a), 32'd0);
    chk("rst_data_b", 32'(d_b), 32'd0);
    chk("rst_rden_a", 32'(rd_en_a), 32'd0);
`ifdef FIFO_RDR_STATS_EN
    chk("rst_popcnt_a", pc_a, 32'd0);
`endif
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Three-word burst: latency and back-to-back delivery.
    m_ready = 1'b1;
    bub_start();
    push(8'h11); push(8'h22); push(8'h33);
    latency(la, lb);
    chk("latency_regout1", 32'(la), 32'd2);
    chk("latency_regout0", 32'(lb), 32'd1);
    drain("burst_drain", 20);
    bub_en = 0;
    chk("burst_bubbles_a", 32'(bub_a), 32'd0);
    chk("burst_bubbles_b", 32'(bub_b), 32'd0);

    // Stall for 10 cycles with 16 words queued, then release.
    m_ready = 1'b0;
    rdcnt_a = 0; rdcnt_b = 0; rdwin = 1;
    for (int i = 0; i < 16; i++) push(W'($urandom));
    tick(10);
    rdwin = 0;
    chk("stall_rden_a", 32'(rdcnt_a), 32'd2);
    chk("stall_rden_b", 32'(rdcnt_b), 32'd2);
    chk("stall_head_a", 32'(d_a), 32'(exp_a[0]));
    chk("stall_head_b", 32'(d_b), 32'(exp_b[0]));
    bub_start();
    m_ready = 1'b1;
    drain("stall_drain", 60);
    bub_en = 0;
    chk("stall_bubbles_a", 32'(bub_a), 32'd0);
    chk("stall_bubbles_b", 32'(bub_b), 32'd0);

    // Alternating m_ready.
    for (int i = 0; i < 16; i++) push(W'($urandom));
    for (int k = 0; k < 200 && (exp_a.size() + exp_b.size()) != 0; k++) begin
      m_ready = (k % 2 == 0);
      tick();
    end
    m_ready = 1'b1;
    drain("toggle_drain", 4);

    // Fill both entries, flush, refill with a fresh word.
    m_ready = 1'b0;
    push(8'hC1); push(8'hC2);
    tick(4);
    chk("full_valid_a", 32'(v_a), 32'd1);
    chk("full_valid_b", 32'(v_b), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_a.delete();
    exp_b.delete();
    chk("clr_valid_a", 32'(v_a), 32'd0);
    chk("clr_valid_b", 32'(v_b), 32'd0);
    tick();
    push(8'h5A);
    m_ready = 1'b1;
    drain("clr_refill_drain", 20);

    // Random pushes and random backpressure.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 1) == 1) push(W'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    m_ready = 1'b1;
    drain("random_drain", 100);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 16; i++) push(W'($urandom));
    tick(4);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid_a", 32'(v_a), 32'd0);
    chk("async_rst_valid_b", 32'(v_b), 32'd0);
    exp_a.delete();
    exp_b.delete();
    tick(2);
    rst_n = 1'b1;
`ifdef FIFO_RDR_STATS_EN
    chk("popcnt_after_rst_a", pc_a, 32'd0);
    chk("popcnt_after_rst_b", pc_b, 32'd0);
`endif
    tick();

    // Continuous 16-word stream after reset: latency and full throughput.
    bub_start();
    for (int i = 0; i < 16; i++) push(W'($urandom));
    latency(la, lb);
    chk("stream_latency_regout1", 32'(la), 32'd2);
    chk("stream_latency_regout0", 32'(lb), 32'd1);
    drain("stream_drain", 40);
    bub_en = 0;
    chk("stream_bubbles_a", 32'(bub_a), 32'd0);
    chk("stream_bubbles_b", 32'(bub_b), 32'd0);
`ifdef FIFO_RDR_STATS_EN
    chk("popcnt_16_a", pc_a, 32'd16);
    chk("popcnt_16_b", pc_b, 32'd16);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
